// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the data-memory access sequencer.
//   - Memory access size encodings and data window base address.
//   - Error codes reported on rsp_err_code.
//   - Sequencer state encoding.
package mem_access_unit_pkg;

  // Access size encodings understood by the data memory; 2'b11 is undefined.
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [31:0] DATA_BASE_ADDRESS = 32'h1001_0000;

  localparam logic [1:0] MAU_ERR_NONE  = 2'd0;
  localparam logic [1:0] MAU_ERR_ALIGN = 2'd1;
  localparam logic [1:0] MAU_ERR_RANGE = 2'd2;
  localparam logic [1:0] MAU_ERR_OP    = 2'd3;

  typedef enum logic [1:0] {
    MAU_IDLE   = 2'd0,
    MAU_ACCESS = 2'd1,
    MAU_RESP   = 2'd2,
    MAU_ERR    = 2'd3
  } mau_state_e;

endpackage

// File: rtl/mau_req_check.sv
// Combinational request validator for mem_access_unit.
// Ports:
//   op       in  2   requested access size
//   addr     in  32  requested byte address
//   ok       out 1   request may proceed to memory
//   err_code out 2   first failing check: bad op, then range, then alignment
module mau_req_check
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DATA_SIZE_BYTES = 4096
) (
  input  logic [1:0]  op,
  input  logic [31:0] addr,
  output logic        ok,
  output logic [1:0]  err_code
);

  logic [31:0] offset;
  logic        misaligned;

  // Unsigned subtraction: addresses below the base wrap to huge offsets and fail.
  assign offset     = addr - DATA_BASE_ADDRESS;
  assign misaligned = ((op == MEM_HALF) && addr[0]) ||
                      ((op == MEM_WORD) && (addr[1:0] != 2'b00));

  always_comb begin
    err_code = MAU_ERR_NONE;
    if (op == 2'b11) begin
      err_code = MAU_ERR_OP;
    end else if (offset >= 32'(DATA_SIZE_BYTES)) begin
      err_code = MAU_ERR_RANGE;
    end else if (misaligned) begin
      err_code = MAU_ERR_ALIGN;
    end
  end

  assign ok = (err_code == MAU_ERR_NONE);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer sitting directly in front of the data memory.
// Accepts one request at a time, validates it, drives the memory for exactly one
// cycle and captures load data into the MDR (rsp_rdata).
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_write/op/ext/addr/wdata      request fields
//   rsp_valid/rsp_err/rsp_err_code   completion pulse and error status
//   rsp_rdata                        MDR, updated only by completed loads
//   bad_addr                         address of the last rejected request
//   dm_wr/dm_read/dm_op/dm_ext/dm_addr/dm_din  registered memory controls
//   dm_dout                          memory read data
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DATA_SIZE_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_op,
  input  logic        req_ext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [1:0]  rsp_err_code,
  output logic [31:0] rsp_rdata,
  output logic [31:0] bad_addr,
  output logic        dm_wr,
  output logic        dm_read,
  output logic [1:0]  dm_op,
  output logic        dm_ext,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout
);

  mau_state_e  state_q, state_d;
  logic        dm_wr_q, dm_wr_d;
  logic        dm_read_q, dm_read_d;
  logic [1:0]  dm_op_q, dm_op_d;
  logic        dm_ext_q, dm_ext_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_din_q, dm_din_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [1:0]  rsp_err_code_q, rsp_err_code_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] bad_addr_q, bad_addr_d;

  logic        chk_ok;
  logic [1:0]  chk_code;

  mau_req_check #(
    .DATA_SIZE_BYTES(DATA_SIZE_BYTES)
  ) u_req_check (
    .op      (req_op),
    .addr    (req_addr),
    .ok      (chk_ok),
    .err_code(chk_code)
  );

  // The dm_* registers double as the latched request; they are only loaded for
  // accepted valid requests so dm_dout stays stable otherwise.
  always_comb begin
    state_d        = state_q;
    dm_wr_d        = 1'b0;
    dm_read_d      = 1'b0;
    dm_op_d        = dm_op_q;
    dm_ext_d       = dm_ext_q;
    dm_addr_d      = dm_addr_q;
    dm_din_d       = dm_din_q;
    rsp_valid_d    = 1'b0;
    rsp_err_d      = 1'b0;
    rsp_err_code_d = rsp_err_code_q;
    rsp_rdata_d    = rsp_rdata_q;
    bad_addr_d     = bad_addr_q;

    unique case (state_q)
      MAU_IDLE: begin
        if (req_valid) begin
          if (chk_ok) begin
            state_d   = MAU_ACCESS;
            dm_wr_d   = req_write;
            dm_read_d = !req_write;
            dm_op_d   = req_op;
            dm_ext_d  = req_ext;
            dm_addr_d = req_addr;
            dm_din_d  = req_wdata;
          end else begin
            state_d        = MAU_ERR;
            rsp_valid_d    = 1'b1;
            rsp_err_d      = 1'b1;
            rsp_err_code_d = chk_code;
            bad_addr_d     = req_addr;
          end
        end
      end
      MAU_ACCESS: begin
        state_d        = MAU_RESP;
        rsp_valid_d    = 1'b1;
        rsp_err_code_d = MAU_ERR_NONE;
        if (dm_read_q) begin
          rsp_rdata_d = dm_dout;
        end
      end
      MAU_RESP: state_d = MAU_IDLE;
      MAU_ERR:  state_d = MAU_IDLE;
      default:  state_d = MAU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= MAU_IDLE;
      dm_wr_q        <= 1'b0;
      dm_read_q      <= 1'b0;
      dm_op_q        <= MEM_WORD;
      dm_ext_q       <= 1'b0;
      dm_addr_q      <= DATA_BASE_ADDRESS;
      dm_din_q       <= 32'h0;
      rsp_valid_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_err_code_q <= MAU_ERR_NONE;
      rsp_rdata_q    <= 32'h0;
      bad_addr_q     <= 32'h0;
    end else begin
      state_q        <= state_d;
      dm_wr_q        <= dm_wr_d;
      dm_read_q      <= dm_read_d;
      dm_op_q        <= dm_op_d;
      dm_ext_q       <= dm_ext_d;
      dm_addr_q      <= dm_addr_d;
      dm_din_q       <= dm_din_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_err_q      <= rsp_err_d;
      rsp_err_code_q <= rsp_err_code_d;
      rsp_rdata_q    <= rsp_rdata_d;
      bad_addr_q     <= bad_addr_d;
    end
  end

  assign req_ready    = (state_q == MAU_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_err_code = rsp_err_code_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign bad_addr     = bad_addr_q;
  assign dm_wr        = dm_wr_q;
  assign dm_read      = dm_read_q;
  assign dm_op        = dm_op_q;
  assign dm_ext       = dm_ext_q;
  assign dm_addr      = dm_addr_q;
  assign dm_din       = dm_din_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a byte-addressed data memory model
// (combinational read, write on the negedge inside the ACCESS cycle).
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam logic [31:0] B = DATA_BASE_ADDRESS;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_ext;
  logic [1:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [1:0]  rsp_err_code;
  logic [31:0] rsp_rdata, bad_addr;
  logic        dm_wr, dm_read, dm_ext;
  logic [1:0]  dm_op;
  logic [31:0] dm_addr, dm_din, dm_dout;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  logic [7:0]  mem [0:4095];
  logic [11:0] ia;
  logic [7:0]  b0, b1, b2, b3;

  always #5 clk = ~clk;

  mem_access_unit #(
    .DATA_SIZE_BYTES(4096)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_op      (req_op),
    .req_ext     (req_ext),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_err_code(rsp_err_code),
    .rsp_rdata   (rsp_rdata),
    .bad_addr    (bad_addr),
    .dm_wr       (dm_wr),
    .dm_read     (dm_read),
    .dm_op       (dm_op),
    .dm_ext      (dm_ext),
    .dm_addr     (dm_addr),
    .dm_din      (dm_din),
    .dm_dout     (dm_dout)
  );

  // Base is 4 KiB aligned, so the window offset is the low 12 address bits.
  always_comb begin
    ia = dm_addr[11:0];
    b0 = mem[ia];
    b1 = mem[ia + 12'd1];
    b2 = mem[ia + 12'd2];
    b3 = mem[ia + 12'd3];
    case (dm_op)
      MEM_BYTE: dm_dout = {{24{dm_ext & b0[7]}}, b0};
      MEM_HALF: dm_dout = {{16{dm_ext & b1[7]}}, b1, b0};
      default:  dm_dout = {b3, b2, b1, b0};
    endcase
  end

  always @(negedge clk) begin
    if (dm_wr) begin
      mem[dm_addr[11:0]] <= dm_din[7:0];
      if (dm_op != MEM_BYTE) mem[dm_addr[11:0] + 12'd1] <= dm_din[15:8];
      if (dm_op == MEM_WORD) begin
        mem[dm_addr[11:0] + 12'd2] <= dm_din[23:16];
        mem[dm_addr[11:0] + 12'd3] <= dm_din[31:24];
      end
    end
    if (dm_wr) wr_cnt++;
    if (dm_read) rd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] op, input logic ext,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_write = w;
    req_op    = op;
    req_ext   = ext;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
  endtask

  task automatic do_ok(input string tag, input logic w, input logic [1:0] op, input logic ext,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata);
    int wc, rc;
    @(negedge clk);
    drive(w, op, ext, addr, wdata);
    wc = wr_cnt;
    rc = rd_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk({tag, "_acc_wr"}, 32'(dm_wr), 32'(w));
    chk({tag, "_acc_rd"}, 32'(dm_read), 32'(!w));
    chk({tag, "_acc_addr"}, dm_addr, addr);
    chk({tag, "_acc_ready"}, 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rsp_code"}, 32'(rsp_err_code), 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_rsp_wr"}, 32'(dm_wr), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_wr_cycles"}, 32'(wr_cnt - wc), 32'(w));
    chk({tag, "_rd_cycles"}, 32'(rd_cnt - rc), 32'(!w));
  endtask

  task automatic do_err(input string tag, input logic w, input logic [1:0] op,
                        input logic [31:0] addr, input logic [1:0] code);
    int wc, rc;
    @(negedge clk);
    drive(w, op, 1'b0, addr, 32'hCAFE_F00D);
    wc = wr_cnt;
    rc = rd_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_err"}, 32'(rsp_err), 32'd1);
    chk({tag, "_code"}, 32'(rsp_err_code), 32'(code));
    chk({tag, "_bad_addr"}, bad_addr, addr);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_no_wr"}, 32'(wr_cnt - wc), 32'd0);
    chk({tag, "_no_rd"}, 32'(rd_cnt - rc), 32'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_code"}, 32'(rsp_err_code), 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_bad_addr"}, bad_addr, 32'd0);
    chk({tag, "_dm_wr"}, 32'(dm_wr), 32'd0);
    chk({tag, "_dm_read"}, 32'(dm_read), 32'd0);
    chk({tag, "_dm_op"}, 32'(dm_op), 32'(MEM_WORD));
    chk({tag, "_dm_ext"}, 32'(dm_ext), 32'd0);
    chk({tag, "_dm_addr"}, dm_addr, B);
    chk({tag, "_dm_din"}, dm_din, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pat;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_op    = MEM_WORD;
    req_ext   = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 chk_reset_values("por");
    @(negedge clk);
    rst = 1'b0;

    // Word store/load round trip.
    do_ok("st_w10", 1'b1, MEM_WORD, 1'b0, B + 32'h10, 32'hDEAD_BEEF, 32'h0);
    do_ok("ld_w10", 1'b0, MEM_WORD, 1'b0, B + 32'h10, 32'h0, 32'hDEAD_BEEF);

    // Byte store then signed/unsigned byte loads.
    do_ok("st_b13", 1'b1, MEM_BYTE, 1'b0, B + 32'h13, 32'h0000_0080, 32'hDEAD_BEEF);
    do_ok("ld_bs13", 1'b0, MEM_BYTE, 1'b1, B + 32'h13, 32'h0, 32'hFFFF_FF80);
    do_ok("ld_bu13", 1'b0, MEM_BYTE, 1'b0, B + 32'h13, 32'h0, 32'h0000_0080);

    // Half store/load with sign extension, then misaligned half.
    do_ok("st_h6", 1'b1, MEM_HALF, 1'b0, B + 32'h6, 32'h0000_8001, 32'h0000_0080);
    do_ok("ld_h6", 1'b0, MEM_HALF, 1'b1, B + 32'h6, 32'h0, 32'hFFFF_8001);
    do_err("ld_h5", 1'b0, MEM_HALF, B + 32'h5, MAU_ERR_ALIGN);

    // Range failures above and below the window; bad op beats misalignment.
    do_err("st_top", 1'b1, MEM_WORD, B + 32'd4096, MAU_ERR_RANGE);
    do_err("st_below", 1'b1, MEM_WORD, B - 32'd4, MAU_ERR_RANGE);
    do_err("op3", 1'b0, 2'b11, B + 32'h3, MAU_ERR_OP);
    chk("rdata_held_after_err", rsp_rdata, 32'hFFFF_8001);

    // Word reflects the byte overwrite at 0x13; error code clears on success.
    do_ok("ld_w10b", 1'b0, MEM_WORD, 1'b0, B + 32'h10, 32'h0, 32'h80AD_BEEF);

    // Reset pulse inside ACCESS of a store, before the write negedge.
    @(negedge clk);
    drive(1'b1, MEM_WORD, 1'b0, B + 32'h20, 32'h1234_5678);
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("rst_pre_wr", 32'(dm_wr), 32'd1);
    #1 rst = 1'b1;
    #1 chk_reset_values("rst_mid");
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mem_b0", 32'(mem[12'h020]), 32'h0);
    chk("rst_mem_b3", 32'(mem[12'h023]), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    do_ok("ld_w20", 1'b0, MEM_WORD, 1'b0, B + 32'h20, 32'h0, 32'h0);

    // Back-to-back loads with req_valid held high: accepts every third edge.
    @(negedge clk);
    drive(1'b0, MEM_WORD, 1'b0, B + 32'h10, 32'h0);
    pat    = 12'h0;
    pat[0] = req_ready;
    for (int i = 1; i < 12; i++) begin
      @(negedge clk);
      pat[i] = req_ready;
      if (i == 10) req_valid = 1'b0;
    end
    chk("b2b_ready_pattern", 32'(pat), 32'h249);
    chk("b2b_rdata", rsp_rdata, 32'h80AD_BEEF);
    repeat (2) @(posedge clk);
    #1 chk("b2b_final_ready", 32'(req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequencer that sits directly upstream of the data memory in the multi-cycle CPU: it accepts one load/store request at a time from the control FSM and validates alignment, range and op encoding. It then drives the data memory's write/read/op/extension/address/data inputs for exactly one clock and captures the read word into an internal memory data register (MDR). Rejected requests never reach the memory and are reported with an error code and the faulting address.

## Interface
Parameters:
- DATA_SIZE_BYTES, 4096: size of the data memory window starting at `DATA_BASE_ADDRESS`; must be a power of two.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock; all state on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_op  in  2  `MEM_BYTE` / `MEM_HALF` / `MEM_WORD`
- req_ext  in  1  load extension: 0 = zero, 1 = sign
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low bits used for byte/half
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  qualifies rsp_valid; request rejected
- rsp_err_code  out  2  0 none, 1 misaligned, 2 out of range, 3 bad op
- rsp_rdata  out  32  MDR; held until the next load completes
- bad_addr  out  32  address of the last rejected request; held
- dm_wr, dm_read  out  1 each  memory write / read strobes
- dm_op  out  2  memory access size
- dm_ext  out  1  memory extension select
- dm_addr, dm_din  out  32 each  memory address / write data
- dm_dout  in  32  memory read data, combinational from dm_addr/dm_op/dm_ext

## Operation
- States: IDLE, ACCESS, RESP, ERR.
  - IDLE: on req_valid, latch the request into registers.
  - Valid request -> ACCESS. Invalid request -> ERR.
  - ACCESS -> RESP, unconditionally.
  - RESP -> IDLE. ERR -> IDLE.
- Validation, in priority order:
  - req_op = 2'b11 -> bad op (3).
  - (req_addr - `DATA_BASE_ADDRESS`) >= DATA_SIZE_BYTES, unsigned 32-bit subtraction (addresses below base wrap and fail) -> out of range (2).
  - Half with addr[0] != 0, or word with addr[1:0] != 0 -> misaligned (1).
  - Byte accesses are never misaligned.
- ACCESS:
  - dm_wr = req_write; dm_read = !req_write.
  - dm_op, dm_ext, dm_addr, dm_din are driven from the latched registers.
- End of ACCESS: for loads, rsp_rdata <= dm_dout. Stores leave rsp_rdata unchanged.
- ERR:
  - bad_addr <= latched address.
  - rsp_valid = rsp_err = 1 and rsp_err_code is set.
  - dm_wr and dm_read stay 0 throughout.
- dm_op, dm_ext, dm_addr and dm_din hold their last values outside ACCESS, so dm_dout stays stable. dm_wr and dm_read are 0 outside ACCESS.
- rsp_err_code returns to 0 on the next valid response.

## Timing
- Accept at edge N (IDLE and req_valid).
- Valid request:
  - ACCESS during cycle N+1; the memory write lands on the negedge inside that cycle.
  - rsp_valid is high during cycle N+2.
  - Next accept no earlier than edge N+3, i.e. 3-cycle throughput.
- Invalid request: rsp_valid and rsp_err are high during cycle N+1; next accept at edge N+2.
- All dm_* and rsp_* outputs are registered (glitch-free strobes).
- Reset values:
  - state IDLE, req_ready 1 after deassert.
  - rsp_valid 0, rsp_err 0, rsp_err_code 0, rsp_rdata 0, bad_addr 0.
  - dm_wr 0, dm_read 0, dm_op `MEM_WORD`, dm_ext 0, dm_addr `DATA_BASE_ADDRESS`, dm_din 0.
- Reset asserted during ACCESS drops dm_wr immediately (asynchronous). If it asserts before the mid-cycle negedge, no write occurs.
- A request held on req_valid across reset is accepted at the first posedge after deassert.
- req_* inputs are ignored outside IDLE.

## Structure
- `ctrl_encode_def.v` holds the shared constants:
  - existing: `MEM_BYTE`, `MEM_HALF`, `MEM_WORD`, `DATA_BASE_ADDRESS`.
  - new: `MAU_ERR_NONE`, `MAU_ERR_ALIGN`, `MAU_ERR_RANGE`, `MAU_ERR_OP`.
  - new: state codes `MAU_IDLE`, `MAU_ACCESS`, `MAU_RESP`, `MAU_ERR`.
- One combinational sub-module, `mau_req_check` (inputs op, addr; outputs ok, err_code), encapsulates the validation priority.

## Test plan
- Store word 0xDEADBEEF at BASE+0x10, then load word at BASE+0x10 -> dm_wr high for exactly one cycle at N+1; the load's rsp_rdata = 0xDEADBEEF at its N+2.
- Store byte 0x80 at BASE+0x13, then signed and unsigned byte loads from BASE+0x13 -> 0xFFFFFF80, then 0x00000080; rsp_err = 0.
- Load half at BASE+0x6 with req_ext = 1 after storing 0x8001 there -> rsp_rdata = 0xFFFF8001. Load half at BASE+0x5 -> rsp_err = 1, code 1, bad_addr = BASE+0x5, dm_read never high.
- Store word at BASE+DATA_SIZE_BYTES, and at BASE-4 -> code 2 both times, no dm_wr. Request with req_op = 2'b11 at BASE+0x3 -> code 3 (takes priority over misaligned).
- Assert rst for a few ns in ACCESS of a store to BASE+0x20, before the negedge -> word at BASE+0x20 unchanged; all outputs at reset values; req_ready = 1 after deassert.
- Back-to-back req_valid held high for 4 loads -> accepts at edges 0, 3, 6, 9; req_ready low in ACCESS and RESP.
